// File: rtl/sw_debounce.sv
// sw_debounce: per-channel switch conditioning.
// Each raw switch bit is synchronised, then debounced by a counter that
// requires a new level to hold for CNT_MAX cycles before it is accepted.
// Outputs are the clean level plus one-cycle rise/fall strobes.
// Optional macro SW_DEBOUNCE_LATCH_EN adds a sticky 'changed' flag per
// channel with a clr_changed input.
module sw_debounce #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_MAX     = 250000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             stable
`ifdef SW_DEBOUNCE_LATCH_EN
  ,
  input  logic             clr_changed,
  output logic [WIDTH-1:0] changed
`endif
);

  localparam int unsigned CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic {
    MATCH,
    COUNT
  } chan_state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  chan_state_t      state  [WIDTH];
  logic [CW-1:0]    cnt    [WIDTH];

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift each raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-channel MATCH/COUNT debouncer with registered level and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state[i] <= MATCH;
        cnt[i]   <= '0;
      end
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        case (state[i])
          MATCH: begin
            if (sync[i] != sw_clean[i]) begin
              cnt[i]   <= CW'(1);
              state[i] <= COUNT;
            end else begin
              cnt[i] <= '0;
            end
          end
          COUNT: begin
            if (sync[i] == sw_clean[i]) begin
              cnt[i]   <= '0;
              state[i] <= MATCH;
            end else if (cnt[i] == CNT_LAST) begin
              sw_clean[i] <= sync[i];
              sw_rise[i]  <= sync[i];
              sw_fall[i]  <= ~sync[i];
              cnt[i]      <= '0;
              state[i]    <= MATCH;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            cnt[i]   <= '0;
            state[i] <= MATCH;
          end
        endcase
      end
    end
  end

  // Stable when no channel is counting towards a new level.
  always_comb begin
    stable = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (state[i] == COUNT) begin
        stable = 1'b0;
      end
    end
  end

`ifdef SW_DEBOUNCE_LATCH_EN
  // Sticky change flags; a strobe in the clearing cycle keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= '0;
    end else begin
      changed <= (changed & {WIDTH{~clr_changed}}) | sw_rise | sw_fall;
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce with CNT_MAX=4, SYNC_STAGES=2, WIDTH=8.
// Stimulus is applied on the falling edge; expected post-edge values are
// queued and compared 1 time unit after the following rising edge.
module tb_sw_debounce;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_raw;
  logic         clr_changed;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         stable;
`ifdef SW_DEBOUNCE_LATCH_EN
  logic [W-1:0] changed;
`endif

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH      (W),
    .CNT_MAX    (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .stable     (stable)
`ifdef SW_DEBOUNCE_LATCH_EN
    ,
    .clr_changed(clr_changed),
    .changed    (changed)
`endif
  );

  typedef struct {
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       stab;
    logic       chkc;
    logic [7:0] chg;
    int         tag;
  } exp_t;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       stab;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  task automatic chk(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what must be seen after the next edge.
  task automatic drive(input logic rst, input logic clr, input logic [7:0] sw,
                       input logic [7:0] clean, input logic [7:0] rise,
                       input logic [7:0] fall, input logic stab,
                       input logic chkc, input logic [7:0] chg);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    clr_changed = clr;
    sw_raw      = sw;
    step++;
    e.clean = clean; e.rise = rise; e.fall = fall; e.stab = stab;
    e.chkc  = chkc;  e.chg  = chg;  e.tag  = step;
    sb.push_back(e);
  endtask

  function automatic logic stab_at(input int k);
    return !(k >= 3 && k <= 5);
  endfunction

  // Scoreboard: compare queued expectations just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("sw_clean", mon_e.tag, sw_clean, mon_e.clean);
      chk("sw_rise",  mon_e.tag, sw_rise,  mon_e.rise);
      chk("sw_fall",  mon_e.tag, sw_fall,  mon_e.fall);
      chk("stable",   mon_e.tag, {7'b0, stable}, {7'b0, mon_e.stab});
`ifdef SW_DEBOUNCE_LATCH_EN
      if (mon_e.chkc) chk("changed", mon_e.tag, changed, mon_e.chg);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t       tbl[28];
  logic [7:0] blk_sw[4];
  logic [7:0] old_lvl;

  initial begin
    // Accept sequences: 00->01, 01->FF, FF->0F, 0F->07, 7 cycles each.
    blk_sw[0] = 8'h01; blk_sw[1] = 8'hFF; blk_sw[2] = 8'h0F; blk_sw[3] = 8'h07;
    old_lvl = 8'h00;
    for (int b = 0; b < 4; b++) begin
      for (int k = 1; k <= 7; k++) begin
        tbl[b*7+k-1].sw    = blk_sw[b];
        tbl[b*7+k-1].clean = (k >= 6) ? blk_sw[b] : old_lvl;
        tbl[b*7+k-1].rise  = (k == 6) ? (blk_sw[b] & ~old_lvl) : 8'h00;
        tbl[b*7+k-1].fall  = (k == 6) ? (old_lvl & ~blk_sw[b]) : 8'h00;
        tbl[b*7+k-1].stab  = stab_at(k);
      end
      old_lvl = blk_sw[b];
    end

    rst_n       = 1'b0;
    sw_raw      = '0;
    clr_changed = 1'b0;
    #12;
    chk("reset sw_clean", 0, sw_clean, 8'h00);
    chk("reset sw_rise",  0, sw_rise,  8'h00);
    chk("reset sw_fall",  0, sw_fall,  8'h00);
    chk("reset stable",   0, {7'b0, stable}, 8'h01);

    // Idle after release.
    for (int c = 0; c < 20; c++) drive(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);

    // Five 2-cycle high pulses on bit 0 must never be accepted.
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1, 0, (c < 2) ? 8'h01 : 8'h00, 8'h00, 8'h00, 8'h00, (c < 2), 0, 8'h00);
      end
    end
    drive(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);
    drive(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);

    // Table-driven acceptances.
    for (int i = 0; i < 28; i++) begin
      drive(1, 0, tbl[i].sw, tbl[i].clean, tbl[i].rise, tbl[i].fall, tbl[i].stab, 0, 8'h00);
    end

    // Reset mid-count after a 0->1 change on bit 3 (clean is 07).
    for (int k = 1; k <= 4; k++) drive(1, 0, 8'h0F, 8'h07, 8'h00, 8'h00, stab_at(k), 0, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst sw_clean", step, sw_clean, 8'h00);
    chk("async rst sw_rise",  step, sw_rise,  8'h00);
    chk("async rst sw_fall",  step, sw_fall,  8'h00);
    chk("async rst stable",   step, {7'b0, stable}, 8'h01);
    drive(0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);
    drive(0, 0, 8'h0F, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, 8'h0F, (k >= 6) ? 8'h0F : 8'h00, (k == 6) ? 8'h0F : 8'h00, 8'h00,
            stab_at(k), 0, 8'h00);
    end

    // Sticky change flags (only compared when the feature is built in).
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, 8'h0B, (k >= 6) ? 8'h0B : 8'h0F, 8'h00, (k == 6) ? 8'h04 : 8'h00,
            stab_at(k), 0, 8'h00);
    end
    drive(1, 1, 8'h0B, 8'h0B, 8'h00, 8'h00, 1, 1, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      drive(1, 0, 8'h0F, (k >= 6) ? 8'h0F : 8'h0B, (k == 6) ? 8'h04 : 8'h00, 8'h00,
            stab_at(k), 1, (k == 7) ? 8'h04 : 8'h00);
    end
    for (int k = 1; k <= 7; k++) begin
      drive(1, (k == 7), 8'h0B, (k >= 6) ? 8'h0B : 8'h0F, 8'h00, (k == 6) ? 8'h04 : 8'h00,
            stab_at(k), 1, 8'h04);
    end
    drive(1, 1, 8'h0B, 8'h0B, 8'h00, 8'h00, 1, 1, 8'h00);
    drive(1, 0, 8'h0B, 8'h0B, 8'h00, 8'h00, 1, 1, 8'h00);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input conditioning stage that sits directly upstream of the switch-driven logic: the stair light and the 1-bit/2-bit adders.
- Each raw slide-switch input passes through a synchroniser and a per-channel counter-based debouncer.
- Outputs are clean, glitch-free levels plus one-cycle rise/fall strobes.
- The top level routes sw_clean[7:0] to the light/adder instances in place of the raw sw0..sw7 pins.

Parameters:
- WIDTH, 8: number of switch channels.
- CNT_MAX, 250000: consecutive cycles a new level must hold before acceptance (10 ms at 25 MHz). Legal range ≥2.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser. Legal range ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is sampled by clk.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk; bit i = sw<i>.
- sw_clean  output  WIDTH  debounced level per channel.
- sw_rise  output  WIDTH  one-cycle pulse when sw_clean[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse when sw_clean[i] goes 1->0.
- stable  output  1  high when no channel has a pending (counting) change.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops, counters, sw_clean, sw_rise and sw_fall go to 0.
  - stable goes to 1.
  - Reset mid-count discards the count.
  - A switch already high at reset release is treated as a normal 0->1 change: it is debounced and then produces one sw_rise pulse.
- Synchroniser:
  - sw_raw[i] is shifted through SYNC_STAGES flops.
  - The last stage is sync[i].
  - No logic reads earlier stages.
- Counter:
  - One counter per channel, width clog2(CNT_MAX).
  - Each channel has two states: MATCH (sync[i]==sw_clean[i]) and COUNT (mismatch).
- MATCH:
  - Counter held at 0.
  - If sync[i]!=sw_clean[i] on a clock edge, counter <= 1 and the channel enters COUNT.
- COUNT:
  - If sync[i]==sw_clean[i] (bounce back), counter <= 0 and the channel returns to MATCH. No output change.
  - Else if counter==CNT_MAX-1: sw_clean[i] <= sync[i], counter <= 0, channel returns to MATCH, and the matching rise/fall bit pulses high for exactly one cycle.
  - Else counter increments.
- Latency:
  - Number the first rising edge that samples a new, steady sw_raw level as edge 1.
  - sw_clean changes on edge SYNC_STAGES+CNT_MAX.
  - With defaults that is 250002 cycles.
  - The strobe is asserted in the cycle following that same edge (registered, aligned with the new sw_clean).
- Bounce:
  - Any return to the old level before acceptance restarts the count from 0.
  - A pulse shorter than CNT_MAX synchronised cycles never reaches sw_clean.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous acceptances on several channels pulse all corresponding bits in the same cycle.
- Counter range: never exceeds CNT_MAX-1; no wrap-around is possible.
- stable: combinational NOR of all "channel in COUNT" flags; 0 whenever any counter is non-zero.
- Strobe exclusivity: sw_rise[i] and sw_fall[i] are never high together.

Optional Feature:
- Macro: SW_DEBOUNCE_LATCH_EN.
- When defined:
  - Adds input clr_changed (1 bit) and output changed (WIDTH bits).
  - changed[i] sets to 1 on any sw_rise[i] or sw_fall[i] and stays set until a cycle with clr_changed=1.
  - If clr_changed and a strobe occur in the same cycle, set wins (the bit stays 1).
  - Reset value of changed is 0.
- When not defined: neither port exists and there are no extra flops.

Test Plan (CNT_MAX=4, SYNC_STAGES=2, WIDTH=8):
- Release rst_n with sw_raw=8'h00, run 20 cycles -> sw_clean=8'h00, sw_rise=sw_fall=0, stable=1 throughout.
- Set sw_raw=8'h01 and hold -> sw_clean[0] rises on edge 6, sw_rise=8'h01 for exactly one cycle, stable=0 on edges 3-5 and 1 after.
- Toggle sw_raw[0] 0->1->0 with 2-cycle high pulses, repeated 5 times -> sw_clean stays 8'h00, no strobes, counter returns to 0 after each pulse.
- With sw_clean=8'hFF, drive sw_raw=8'h0F in one cycle -> sw_clean=8'h0F on edge 6, sw_fall=8'hF0 for one cycle, sw_rise=0.
- Assert rst_n=0 asynchronously mid-count (edge 4 after a 0->1 change on bit 3) -> sw_clean, strobes and counters 0 immediately. Keep sw_raw[3]=1 after release -> sw_rise[3] fires on edge 6 after release.
- SW_DEBOUNCE_LATCH_EN defined: accept a rise on bit 2 -> changed=8'h04. Pulse clr_changed in the same cycle as a fall strobe on bit 2 -> changed stays 8'h04. Clear alone -> changed=8'h00 next cycle.
